alu_reservation_station: RTL and testbench

- Reservation station feeding the ALU issue/execute stage.
- Accepts dispatched ALU ops with operands or producer tags, snoops the common data bus (CDB) for missing operands, and issues one fully-ready op per cycle.
- Issue port is the producer side of the RS-to-ALU interface: val1/val2/commands/tag/ready out, stall in.
- The ALU stage is combinational, so an op leaves this block on the same clock edge that it is accepted.

---
 rtl/alu_rs_pkg.sv | 8 +
 rtl/rs_prio_enc.sv | 24 ++
 rtl/alu_reservation_station.sv | 164 ++++++++++++++++
 tb/tb_alu_reservation_station.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths for the ALU reservation station.
// The entry struct lives in the top module because its tag width is a module parameter.
package alu_rs_pkg;

  localparam int COMMAND_W = 10;
  localparam int DATA_W    = 64;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-set-bit encoder with a found flag.
// Used by the station both to pick a free slot and to pick the next op to issue.
module rs_prio_enc #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive from the CDB,
// then issues the lowest-index ready op to the combinational ALU stage.
module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSsize     = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,

  input  logic                  dispatchValid_i,
  input  logic [COMMAND_W-1:0]  dispatchCommands_i,
  input  logic [ROBsizeLog-1:0] dispatchTag_i,
  input  logic [DATA_W-1:0]     dispatchVal1_i,
  input  logic [DATA_W-1:0]     dispatchVal2_i,
  input  logic                  dispatchRdy1_i,
  input  logic                  dispatchRdy2_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc1_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc2_i,
  output logic                  full_o,

  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [DATA_W-1:0]     cdbVal_i,

  output logic [DATA_W-1:0]     reservationStationVal1_o,
  output logic [DATA_W-1:0]     reservationStationVal2_o,
  output logic [COMMAND_W-1:0]  reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o,
  output logic                  readyRS_o,
  input  logic                  stallRS_i
);

  localparam int IDX_W = $clog2(RSsize);

  typedef struct packed {
    logic                  valid;
    logic [COMMAND_W-1:0]  commands;
    logic [ROBsizeLog-1:0] tag;
    logic [DATA_W-1:0]     val1;
    logic                  rdy1;
    logic [ROBsizeLog-1:0] src1;
    logic [DATA_W-1:0]     val2;
    logic                  rdy2;
    logic [ROBsizeLog-1:0] src2;
  } rs_entry_t;

  rs_entry_t r_entries [RSsize];
  rs_entry_t w_next    [RSsize];
  rs_entry_t w_dispatchEntry;

  logic [RSsize-1:0] w_freeVec;
  logic [RSsize-1:0] w_readyVec;
  logic [IDX_W-1:0]  w_freeIdx;
  logic [IDX_W-1:0]  w_readyIdx;
  logic              w_freeFound;
  logic              w_readyFound;
  logic              w_dispatch;
  logic              w_issue;

  // Readiness is taken from registered state only, so anything woken this cycle issues next cycle.
  always_comb begin
    w_freeVec  = '0;
    w_readyVec = '0;
    for (int i = 0; i < RSsize; i++) begin
      w_freeVec[i]  = ~r_entries[i].valid;
      w_readyVec[i] = r_entries[i].valid & r_entries[i].rdy1 & r_entries[i].rdy2;
    end
  end

  rs_prio_enc #(.WIDTH(RSsize), .IDX_W(IDX_W)) u_freeEnc (
    .i_vec   (w_freeVec),
    .o_idx   (w_freeIdx),
    .o_found (w_freeFound)
  );

  rs_prio_enc #(.WIDTH(RSsize), .IDX_W(IDX_W)) u_readyEnc (
    .i_vec   (w_readyVec),
    .o_idx   (w_readyIdx),
    .o_found (w_readyFound)
  );

  assign full_o     = ~w_freeFound;
  assign w_dispatch = dispatchValid_i & w_freeFound;
  assign w_issue    = w_readyFound & ~stallRS_i;
  assign readyRS_o  = w_readyFound;

  // Incoming op, with operands forwarded from a CDB broadcast in the same cycle.
  always_comb begin
    w_dispatchEntry.valid    = 1'b1;
    w_dispatchEntry.commands = dispatchCommands_i;
    w_dispatchEntry.tag      = dispatchTag_i;
    w_dispatchEntry.val1     = dispatchVal1_i;
    w_dispatchEntry.rdy1     = dispatchRdy1_i;
    w_dispatchEntry.src1     = dispatchSrc1_i;
    w_dispatchEntry.val2     = dispatchVal2_i;
    w_dispatchEntry.rdy2     = dispatchRdy2_i;
    w_dispatchEntry.src2     = dispatchSrc2_i;
    if (cdbValid_i && !dispatchRdy1_i && dispatchSrc1_i == cdbTag_i) begin
      w_dispatchEntry.val1 = cdbVal_i;
      w_dispatchEntry.rdy1 = 1'b1;
    end
    if (cdbValid_i && !dispatchRdy2_i && dispatchSrc2_i == cdbTag_i) begin
      w_dispatchEntry.val2 = cdbVal_i;
      w_dispatchEntry.rdy2 = 1'b1;
    end
  end

  // Snoop, issue and dispatch never touch the same slot: issue needs a valid entry, dispatch a free one.
  always_comb begin
    for (int i = 0; i < RSsize; i++) begin
      w_next[i] = r_entries[i];
      if (cdbValid_i && r_entries[i].valid) begin
        if (!r_entries[i].rdy1 && r_entries[i].src1 == cdbTag_i) begin
          w_next[i].val1 = cdbVal_i;
          w_next[i].rdy1 = 1'b1;
        end
        if (!r_entries[i].rdy2 && r_entries[i].src2 == cdbTag_i) begin
          w_next[i].val2 = cdbVal_i;
          w_next[i].rdy2 = 1'b1;
        end
      end
    end
    if (w_issue) begin
      w_next[w_readyIdx].valid = 1'b0;
    end
    if (w_dispatch) begin
      w_next[w_freeIdx] = w_dispatchEntry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < RSsize; i++) begin
        r_entries[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < RSsize; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RSsize; i++) begin
        r_entries[i] <= w_next[i];
      end
    end
  end

  always_comb begin
    reservationStationVal1_o     = '0;
    reservationStationVal2_o     = '0;
    reservationStationCommands_o = '0;
    reservationStationTag_o      = '0;
    if (w_readyFound) begin
      reservationStationVal1_o     = r_entries[w_readyIdx].val1;
      reservationStationVal2_o     = r_entries[w_readyIdx].val2;
      reservationStationCommands_o = r_entries[w_readyIdx].commands;
      reservationStationTag_o      = r_entries[w_readyIdx].tag;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for the ALU reservation station: stimulus pushes expected issues into a
// scoreboard queue and a negedge monitor pops and compares every op the DUT hands to the ALU.
module tb_alu_reservation_station;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          flush_i;
  logic          dispatchValid_i;
  logic [9:0]    dispatchCommands_i;
  logic [TW-1:0] dispatchTag_i;
  logic [63:0]   dispatchVal1_i;
  logic [63:0]   dispatchVal2_i;
  logic          dispatchRdy1_i;
  logic          dispatchRdy2_i;
  logic [TW-1:0] dispatchSrc1_i;
  logic [TW-1:0] dispatchSrc2_i;
  logic          full_o;
  logic          cdbValid_i;
  logic [TW-1:0] cdbTag_i;
  logic [63:0]   cdbVal_i;
  logic [63:0]   reservationStationVal1_o;
  logic [63:0]   reservationStationVal2_o;
  logic [9:0]    reservationStationCommands_o;
  logic [TW-1:0] reservationStationTag_o;
  logic          readyRS_o;
  logic          stallRS_i;

  typedef struct {
    logic [63:0]   v1;
    logic [63:0]   v2;
    logic [9:0]    cmd;
    logic [TW-1:0] tag;
  } expIssue_t;

  expIssue_t sbQ[$];
  expIssue_t popped;
  int testsRun    = 0;
  int testsFailed = 0;

  alu_reservation_station #(.ROBsize(8), .RSsize(4)) dut (
    .clk_i                        (clk),
    .reset_i                      (reset_i),
    .flush_i                      (flush_i),
    .dispatchValid_i              (dispatchValid_i),
    .dispatchCommands_i           (dispatchCommands_i),
    .dispatchTag_i                (dispatchTag_i),
    .dispatchVal1_i               (dispatchVal1_i),
    .dispatchVal2_i               (dispatchVal2_i),
    .dispatchRdy1_i               (dispatchRdy1_i),
    .dispatchRdy2_i               (dispatchRdy2_i),
    .dispatchSrc1_i               (dispatchSrc1_i),
    .dispatchSrc2_i               (dispatchSrc2_i),
    .full_o                       (full_o),
    .cdbValid_i                   (cdbValid_i),
    .cdbTag_i                     (cdbTag_i),
    .cdbVal_i                     (cdbVal_i),
    .reservationStationVal1_o     (reservationStationVal1_o),
    .reservationStationVal2_o     (reservationStationVal2_o),
    .reservationStationCommands_o (reservationStationCommands_o),
    .reservationStationTag_o      (reservationStationTag_o),
    .readyRS_o                    (readyRS_o),
    .stallRS_i                    (stallRS_i)
  );

  always #5 clk = ~clk;

  // An op is handed over at the next rising edge whenever ready is high and stall is low.
  always @(negedge clk) begin
    if (!reset_i && !flush_i && readyRS_o && !stallRS_i) begin
      testsRun++;
      if (sbQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpectedIssue: got tag=%0d val1=%0h, required no issue",
                 reservationStationTag_o, reservationStationVal1_o);
      end else begin
        popped = sbQ.pop_front();
        if (reservationStationVal1_o !== popped.v1 || reservationStationVal2_o !== popped.v2 ||
            reservationStationCommands_o !== popped.cmd || reservationStationTag_o !== popped.tag) begin
          testsFailed++;
          $display("[TB] FAIL issue: got v1=%0h v2=%0h cmd=%0d tag=%0d, required v1=%0h v2=%0h cmd=%0d tag=%0d",
                   reservationStationVal1_o, reservationStationVal2_o, reservationStationCommands_o,
                   reservationStationTag_o, popped.v1, popped.v2, popped.cmd, popped.tag);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Presents one dispatch for a single clock edge.
  task automatic applyStimulus(input logic [9:0] cmd, input logic [TW-1:0] tag,
                               input logic [63:0] v1, input logic r1, input logic [TW-1:0] s1,
                               input logic [63:0] v2, input logic r2, input logic [TW-1:0] s2);
    dispatchValid_i    = 1'b1;
    dispatchCommands_i = cmd;
    dispatchTag_i      = tag;
    dispatchVal1_i     = v1;
    dispatchRdy1_i     = r1;
    dispatchSrc1_i     = s1;
    dispatchVal2_i     = v2;
    dispatchRdy2_i     = r2;
    dispatchSrc2_i     = s2;
    step();
    dispatchValid_i    = 1'b0;
  endtask

  task automatic pushExp(input logic [63:0] v1, input logic [63:0] v2,
                         input logic [9:0] cmd, input logic [TW-1:0] tag);
    expIssue_t e;
    e.v1 = v1; e.v2 = v2; e.cmd = cmd; e.tag = tag;
    sbQ.push_back(e);
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n = 0;
    while (sbQ.size() != 0 && n < maxCycles) begin
      step();
      n++;
    end
    checkOutput(name, 64'(sbQ.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; stallRS_i = 1'b0;
    dispatchValid_i = 1'b0; dispatchCommands_i = '0; dispatchTag_i = '0;
    dispatchVal1_i = '0; dispatchVal2_i = '0; dispatchRdy1_i = 1'b0; dispatchRdy2_i = 1'b0;
    dispatchSrc1_i = '0; dispatchSrc2_i = '0;
    cdbValid_i = 1'b0; cdbTag_i = '0; cdbVal_i = '0;
    step();
    step();
    reset_i = 1'b0;
    checkOutput("resetReady", 64'(readyRS_o), 64'd0);
    checkOutput("resetFull", 64'(full_o), 64'd0);
    checkOutput("resetVal1", reservationStationVal1_o, 64'd0);
    checkOutput("resetTag", 64'(reservationStationTag_o), 64'd0);

    // Basic ready op: visible one cycle after dispatch, gone the cycle after.
    pushExp(64'd15, 64'd3, 10'd10, 4'd3);
    applyStimulus(10'd10, 4'd3, 64'd15, 1'b1, 4'd0, 64'd3, 1'b1, 4'd0);
    checkOutput("basicReady", 64'(readyRS_o), 64'd1);
    step();
    checkOutput("basicGone", 64'(readyRS_o), 64'd0);

    // Wait on operand 2 from tag 5; an unrelated broadcast must not wake it.
    pushExp(64'h11, 64'h22, 10'd5, 4'd2);
    applyStimulus(10'd5, 4'd2, 64'h11, 1'b1, 4'd0, 64'd0, 1'b0, 4'd5);
    checkOutput("waitNotReady", 64'(readyRS_o), 64'd0);
    cdbValid_i = 1'b1; cdbTag_i = 4'd3; cdbVal_i = 64'h99;
    step();
    checkOutput("wrongTagNotReady", 64'(readyRS_o), 64'd0);
    cdbTag_i = 4'd5; cdbVal_i = 64'h22;
    step();
    cdbValid_i = 1'b0;
    checkOutput("cdbWakeReady", 64'(readyRS_o), 64'd1);
    checkOutput("cdbWakeVal2", reservationStationVal2_o, 64'h22);
    step();
    checkOutput("cdbWakeGone", 64'(readyRS_o), 64'd0);

    // Same-cycle forwarding into a dispatching op.
    pushExp(64'd7, 64'd9, 10'd3, 4'd4);
    cdbValid_i = 1'b1; cdbTag_i = 4'd6; cdbVal_i = 64'd7;
    applyStimulus(10'd3, 4'd4, 64'd0, 1'b0, 4'd6, 64'd9, 1'b1, 4'd0);
    cdbValid_i = 1'b0;
    checkOutput("fwdReady", 64'(readyRS_o), 64'd1);
    checkOutput("fwdVal1", reservationStationVal1_o, 64'd7);
    step();
    checkOutput("fwdGone", 64'(readyRS_o), 64'd0);

    // Fill under stall, reject a fifth dispatch, then drain in slot order.
    stallRS_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pushExp(64'(100 + k), 64'(200 + k), 10'(20 + k), 4'(k + 1));
      applyStimulus(10'(20 + k), 4'(k + 1), 64'(100 + k), 1'b1, 4'd0, 64'(200 + k), 1'b1, 4'd0);
    end
    checkOutput("fillFull", 64'(full_o), 64'd1);
    checkOutput("fillHeadTag", 64'(reservationStationTag_o), 64'd1);
    applyStimulus(10'd99, 4'd7, 64'd777, 1'b1, 4'd0, 64'd888, 1'b1, 4'd0);
    checkOutput("fullStillFull", 64'(full_o), 64'd1);
    stallRS_i = 1'b0;
    step();
    checkOutput("fullDropsAfterIssue", 64'(full_o), 64'd0);
    waitDrain("fillDrain", 10);
    checkOutput("fillDrainedReady", 64'(readyRS_o), 64'd0);

    // Stalled selection moves to a lower-index entry that wakes up.
    stallRS_i = 1'b1;
    applyStimulus(10'd1, 4'd5, 64'd0, 1'b0, 4'd2, 64'd1, 1'b1, 4'd0);
    applyStimulus(10'd2, 4'd6, 64'h66, 1'b1, 4'd0, 64'd6, 1'b1, 4'd0);
    checkOutput("moveFirstTag", 64'(reservationStationTag_o), 64'd6);
    cdbValid_i = 1'b1; cdbTag_i = 4'd2; cdbVal_i = 64'h55;
    step();
    cdbValid_i = 1'b0;
    checkOutput("moveLowerTag", 64'(reservationStationTag_o), 64'd5);
    checkOutput("moveLowerVal1", reservationStationVal1_o, 64'h55);
    pushExp(64'h55, 64'd1, 10'd1, 4'd5);
    pushExp(64'h66, 64'd6, 10'd2, 4'd6);
    stallRS_i = 1'b0;
    waitDrain("moveDrain", 5);
    checkOutput("moveDrainedReady", 64'(readyRS_o), 64'd0);

    // Outputs hold steady across a five-cycle stall, then issue exactly once.
    stallRS_i = 1'b1;
    applyStimulus(10'd9, 4'd8, 64'hAB, 1'b1, 4'd0, 64'hCD, 1'b1, 4'd0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("holdReady", 64'(readyRS_o), 64'd1);
      checkOutput("holdTag", 64'(reservationStationTag_o), 64'd8);
      checkOutput("holdVal2", reservationStationVal2_o, 64'hCD);
      step();
    end
    pushExp(64'hAB, 64'hCD, 10'd9, 4'd8);
    stallRS_i = 1'b0;
    step();
    checkOutput("holdIssuedOnce", 64'(readyRS_o), 64'd0);
    step();
    checkOutput("holdQueueEmpty", 64'(sbQ.size()), 64'd0);

    // Flush beats a same-cycle dispatch.
    stallRS_i = 1'b1;
    applyStimulus(10'd4, 4'd1, 64'd1, 1'b1, 4'd0, 64'd1, 1'b1, 4'd0);
    applyStimulus(10'd4, 4'd2, 64'd2, 1'b1, 4'd0, 64'd2, 1'b1, 4'd0);
    checkOutput("preFlushReady", 64'(readyRS_o), 64'd1);
    flush_i = 1'b1;
    dispatchValid_i = 1'b1; dispatchTag_i = 4'd3; dispatchRdy1_i = 1'b1; dispatchRdy2_i = 1'b1;
    step();
    flush_i = 1'b0;
    dispatchValid_i = 1'b0;
    checkOutput("flushReady", 64'(readyRS_o), 64'd0);
    checkOutput("flushFull", 64'(full_o), 64'd0);
    step();
    checkOutput("flushDroppedDispatch", 64'(readyRS_o), 64'd0);

    // Reset in the middle of operation.
    applyStimulus(10'd6, 4'd4, 64'd3, 1'b1, 4'd0, 64'd4, 1'b1, 4'd0);
    checkOutput("preResetReady", 64'(readyRS_o), 64'd1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    checkOutput("midResetReady", 64'(readyRS_o), 64'd0);
    checkOutput("midResetFull", 64'(full_o), 64'd0);
    checkOutput("midResetVal1", reservationStationVal1_o, 64'd0);
    stallRS_i = 1'b0;
    step();
    checkOutput("postResetIdle", 64'(readyRS_o), 64'd0);

    checkOutput("finalQueueEmpty", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
